// File: rtl/run_splitter.sv
// Run splitter: steers merged records into one of two show-ahead FIFO banks.
// Optional per-bank terminator counters are built when RUN_SPLITTER_STATS_EN is defined.
module run_splitter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_switch,
  output logic                  o_full,
  output logic                  o_dest,
  input  logic                  i_rd_0,
  input  logic                  i_rd_1,
  output logic [DATA_WIDTH-1:0] o_data_0,
  output logic [DATA_WIDTH-1:0] o_data_1,
  output logic                  o_empty_0,
  output logic                  o_empty_1,
  output logic                  o_min_zero_0,
  output logic                  o_min_zero_1,
  output logic [15:0]           o_runs_0,
  output logic [15:0]           o_runs_1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] OCC_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } bank_state_t;

  logic [ADDR_WIDTH:0]   wptr_q  [2];
  logic [ADDR_WIDTH:0]   wptr_d  [2];
  logic [ADDR_WIDTH:0]   rptr_q  [2];
  logic [ADDR_WIDTH:0]   rptr_d  [2];
  logic [ADDR_WIDTH:0]   occ_q   [2];
  logic [ADDR_WIDTH:0]   occ_d   [2];
  bank_state_t           state_q [2];
  bank_state_t           state_d [2];
  logic                  dest_q;
  logic                  dest_d;
  logic [1:0]            wr_en;
  logic [1:0]            rd_en;
  logic [1:0]            rd_req;
  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  assign rd_req = {i_rd_1, i_rd_0};

  // Writes and pops are gated by the bank state so reset-cycle traffic is dropped too.
  always_comb begin
    dest_d = dest_q ^ i_switch;
    wr_en  = '0;
    rd_en  = '0;
    for (int b = 0; b < 2; b++) begin
      wptr_d[b]  = wptr_q[b];
      rptr_d[b]  = rptr_q[b];
      occ_d[b]   = occ_q[b];
      state_d[b] = state_q[b];
      wr_en[b]   = !i_rst && i_valid && (dest_q == 1'(b)) && (state_q[b] != ST_FULL);
      rd_en[b]   = !i_rst && rd_req[b] && (state_q[b] != ST_EMPTY);
      if (wr_en[b]) wptr_d[b] = wptr_q[b] + ONE;
      if (rd_en[b]) rptr_d[b] = rptr_q[b] + ONE;
      case ({wr_en[b], rd_en[b]})
        2'b10:   occ_d[b] = occ_q[b] + ONE;
        2'b01:   occ_d[b] = occ_q[b] - ONE;
        default: occ_d[b] = occ_q[b];
      endcase
      if (occ_d[b] == '0)          state_d[b] = ST_EMPTY;
      else if (occ_d[b] == OCC_MAX) state_d[b] = ST_FULL;
      else                          state_d[b] = ST_PARTIAL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dest_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        wptr_q[b]  <= '0;
        rptr_q[b]  <= '0;
        occ_q[b]   <= '0;
        state_q[b] <= ST_EMPTY;
      end
    end else begin
      dest_q <= dest_d;
      for (int b = 0; b < 2; b++) begin
        wptr_q[b]  <= wptr_d[b];
        rptr_q[b]  <= rptr_d[b];
        occ_q[b]   <= occ_d[b];
        state_q[b] <= state_d[b];
      end
    end
  end

  // Storage is never reset; only the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wr_en[b]) mem_q[b][wptr_q[b][ADDR_WIDTH-1:0]] <= i_data;
    end
  end

  assign o_dest       = dest_q;
  assign o_full       = (state_q[dest_q] == ST_FULL);
  assign o_empty_0    = (state_q[0] == ST_EMPTY);
  assign o_empty_1    = (state_q[1] == ST_EMPTY);
  assign o_data_0     = mem_q[0][rptr_q[0][ADDR_WIDTH-1:0]];
  assign o_data_1     = mem_q[1][rptr_q[1][ADDR_WIDTH-1:0]];
  assign o_min_zero_0 = !o_empty_0 && (o_data_0 == '0);
  assign o_min_zero_1 = !o_empty_1 && (o_data_1 == '0);

`ifdef RUN_SPLITTER_STATS_EN
  logic [15:0] runs_q [2];
  logic [15:0] runs_d [2];

  // Terminator counters saturate rather than wrap.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      runs_d[b] = runs_q[b];
      if (wr_en[b] && (i_data == '0) && (runs_q[b] != 16'hFFFF))
        runs_d[b] = runs_q[b] + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      runs_q[0] <= '0;
      runs_q[1] <= '0;
    end else begin
      runs_q[0] <= runs_d[0];
      runs_q[1] <= runs_d[1];
    end
  end

  assign o_runs_0 = runs_q[0];
  assign o_runs_1 = runs_q[1];
`else
  assign o_runs_0 = '0;
  assign o_runs_1 = '0;
`endif

endmodule

// File: tb/tb_run_splitter.sv
// Directed bench for run_splitter: a vector table plus hand sequences for full/wrap/reset cases.
module tb_run_splitter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_switch = 1'b0;
  logic        o_full;
  logic        o_dest;
  logic        i_rd_0 = 1'b0;
  logic        i_rd_1 = 1'b0;
  logic [31:0] o_data_0;
  logic [31:0] o_data_1;
  logic        o_empty_0;
  logic        o_empty_1;
  logic        o_min_zero_0;
  logic        o_min_zero_1;
  logic [15:0] o_runs_0;
  logic [15:0] o_runs_1;

  int n_pass = 0;
  int n_total = 0;

  run_splitter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_switch(i_switch), .o_full(o_full), .o_dest(o_dest),
    .i_rd_0(i_rd_0), .i_rd_1(i_rd_1), .o_data_0(o_data_0), .o_data_1(o_data_1),
    .o_empty_0(o_empty_0), .o_empty_1(o_empty_1),
    .o_min_zero_0(o_min_zero_0), .o_min_zero_1(o_min_zero_1),
    .o_runs_0(o_runs_0), .o_runs_1(o_runs_1)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        sw, rd0, rd1;
    logic        dest, full, e0, e1;
    logic        c0;
    logic [31:0] d0;
    logic        c1;
    logic [31:0] d1;
    logic        mz0, mz1;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] d, logic sw, logic rd0, logic rd1,
                              logic dest, logic full, logic e0, logic e1,
                              logic c0, logic [31:0] d0, logic c1, logic [31:0] d1,
                              logic mz0, logic mz1);
    vec_t r;
    r.v = v; r.d = d; r.sw = sw; r.rd0 = rd0; r.rd1 = rd1;
    r.dest = dest; r.full = full; r.e0 = e0; r.e1 = e1;
    r.c0 = c0; r.d0 = d0; r.c1 = c1; r.d1 = d1; r.mz0 = mz0; r.mz1 = mz1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic sw,
                     input logic rd0, input logic rd1);
    @(negedge i_clk);
    i_valid = v; i_data = d; i_switch = sw; i_rd_0 = rd0; i_rd_1 = rd1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input logic v, input logic [31:0] d);
    @(negedge i_clk);
    i_rst = 1'b1; i_valid = v; i_data = d; i_switch = 1'b0; i_rd_0 = 1'b1; i_rd_1 = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_valid = 1'b0; i_rd_0 = 1'b0; i_rd_1 = 1'b0;
  endtask

  vec_t tbl [12];
  logic [31:0] q [$];
  logic [15:0] exp_runs;

  initial begin
    tbl[0]  = mk(1, 32'd5, 0, 0, 0,  0, 0, 0, 1,  1, 32'd5, 0, 0,     0, 0);
    tbl[1]  = mk(1, 32'd3, 0, 0, 0,  0, 0, 0, 1,  1, 32'd5, 0, 0,     0, 0);
    tbl[2]  = mk(1, 32'd0, 0, 0, 0,  0, 0, 0, 1,  1, 32'd5, 0, 0,     0, 0);
    tbl[3]  = mk(0, 32'd0, 0, 1, 0,  0, 0, 0, 1,  1, 32'd3, 0, 0,     0, 0);
    tbl[4]  = mk(0, 32'd0, 0, 1, 0,  0, 0, 0, 1,  1, 32'd0, 0, 0,     1, 0);
    tbl[5]  = mk(0, 32'd0, 0, 1, 0,  0, 0, 1, 1,  0, 32'd0, 0, 0,     0, 0);
    tbl[6]  = mk(1, 32'd4, 0, 1, 0,  0, 0, 0, 1,  1, 32'd4, 0, 0,     0, 0);
    tbl[7]  = mk(0, 32'd0, 0, 1, 0,  0, 0, 1, 1,  0, 32'd0, 0, 0,     0, 0);
    tbl[8]  = mk(1, 32'd7, 1, 0, 0,  1, 0, 0, 1,  1, 32'd7, 0, 0,     0, 0);
    tbl[9]  = mk(1, 32'd9, 0, 0, 0,  1, 0, 0, 0,  1, 32'd7, 1, 32'd9, 0, 0);
    tbl[10] = mk(0, 32'd0, 0, 1, 1,  1, 0, 1, 1,  0, 32'd0, 0, 0,     0, 0);
    tbl[11] = mk(0, 32'd0, 1, 0, 0,  0, 0, 1, 1,  0, 32'd0, 0, 0,     0, 0);

    do_reset(1'b1, 32'h1234);
    chk("rst_empty0", 32'(o_empty_0), 32'd1);
    chk("rst_empty1", 32'(o_empty_1), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_dest", 32'(o_dest), 32'd0);
    chk("rst_mz0", 32'(o_min_zero_0), 32'd0);
    chk("rst_mz1", 32'(o_min_zero_1), 32'd0);
    chk("rst_runs0", 32'(o_runs_0), 32'd0);
    chk("rst_runs1", 32'(o_runs_1), 32'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].sw, tbl[i].rd0, tbl[i].rd1);
      chk($sformatf("vec%0d_dest", i), 32'(o_dest), 32'(tbl[i].dest));
      chk($sformatf("vec%0d_full", i), 32'(o_full), 32'(tbl[i].full));
      chk($sformatf("vec%0d_e0", i), 32'(o_empty_0), 32'(tbl[i].e0));
      chk($sformatf("vec%0d_e1", i), 32'(o_empty_1), 32'(tbl[i].e1));
      chk($sformatf("vec%0d_mz0", i), 32'(o_min_zero_0), 32'(tbl[i].mz0));
      chk($sformatf("vec%0d_mz1", i), 32'(o_min_zero_1), 32'(tbl[i].mz1));
      if (tbl[i].c0) chk($sformatf("vec%0d_d0", i), o_data_0, tbl[i].d0);
      if (tbl[i].c1) chk($sformatf("vec%0d_d1", i), o_data_1, tbl[i].d1);
    end

    // Fill bank 0, hold the 17th record while full, then pop+write in one cycle.
    do_reset(1'b0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b0);
      if (i == 14) chk("full_at15", 32'(o_full), 32'd0);
    end
    chk("full_at16", 32'(o_full), 32'd1);
    chk("full_head", o_data_0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
      chk("full_hold", 32'(o_full), 32'd1);
    end
    cyc(1'b1, 32'd100, 1'b0, 1'b1, 1'b0);
    chk("popfull_full", 32'(o_full), 32'd0);
    chk("popfull_head", o_data_0, 32'd2);
    cyc(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
    chk("refill_full", 32'(o_full), 32'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain%0d_e0", k), 32'(o_empty_0), 32'd0);
      chk($sformatf("drain%0d_d0", k), o_data_0, (k < 15) ? 32'(k + 2) : 32'd100);
      cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(o_empty_0), 32'd1);

    // 40 records through bank 1 with interleaved pops, across two pointer wraps.
    do_reset(1'b0, 32'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("wrap_dest", 32'(o_dest), 32'd1);
    begin
      int w = 0;
      int npop = 0;
      int c = 0;
      logic v, rd;
      q.delete();
      while (!(w == 40 && q.size() == 0) && c < 400) begin
        v  = (w < 40) && (c % 3 != 2);
        rd = (c < 20) ? (c % 4 == 0) : (c % 4 != 0);
        cyc(v, 32'(1000 + w), 1'b0, 1'b0, rd);
        if (rd && q.size() > 0) begin
          void'(q.pop_front());
          npop++;
        end
        if (v && q.size() < 16) begin
          q.push_back(32'(1000 + w));
          w++;
        end
        chk($sformatf("wrap%0d_e1", c), 32'(o_empty_1), 32'(q.size() == 0));
        chk($sformatf("wrap%0d_full", c), 32'(o_full), 32'(q.size() == 16));
        if (q.size() > 0) chk($sformatf("wrap%0d_d1", c), o_data_1, q[0]);
        c++;
      end
      chk("wrap_npop", 32'(npop), 32'd40);
    end

    // Reset with traffic buffered discards it; next write goes to bank 0.
    cyc(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hAB, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_e1", 32'(o_empty_1), 32'd0);
    do_reset(1'b1, 32'hBB);
    chk("mid_rst_e0", 32'(o_empty_0), 32'd1);
    chk("mid_rst_e1", 32'(o_empty_1), 32'd1);
    chk("mid_rst_dest", 32'(o_dest), 32'd0);
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("post_rst_d0", o_data_0, 32'h55);
    chk("post_rst_e0", 32'(o_empty_0), 32'd0);
    chk("post_rst_e1", 32'(o_empty_1), 32'd1);

    // Terminator counting on bank 1.
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef RUN_SPLITTER_STATS_EN
    exp_runs = 16'd3;
`else
    exp_runs = 16'd0;
`endif
    chk("runs1_pre", 32'(o_runs_1), 32'(exp_runs));
    chk("runs0_pre", 32'(o_runs_0), 32'd0);
    chk("term_mz1", 32'(o_min_zero_1), 32'd1);
    do_reset(1'b0, 32'd0);
    chk("runs1_post", 32'(o_runs_1), 32'd0);
    chk("term_e1_post", 32'(o_empty_1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/run_splitter.md
RUN_SPLITTER -- requirements
Module: run_splitter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, record width; ADDR_WIDTH, default 4, log2 of bank depth (bank depth = 2**ADDR_WIDTH).
REQ-002 Ports SHALL be as follows; one clock, reset synchronous active-high:
  i_clk  input  1  rising-edge clock
  i_rst  input  1  synchronous active-high reset
  i_valid  input  1  merged record present on i_data (merger not stalled)
  i_data  input  DATA_WIDTH  merged record; all-zero = run terminator
  i_switch  input  1  switch_output pulse from merger control; toggles destination bank
  o_full  output  1  selected bank full; drives merger i_fifo_out_full
  o_dest  output  1  current destination bank (0/1)
  i_rd_0, i_rd_1  input  1  pop head of bank 0/1
  o_data_0, o_data_1  output  DATA_WIDTH  head record of bank 0/1 (show-ahead)
  o_empty_0, o_empty_1  output  1  bank 0/1 empty
  o_min_zero_0, o_min_zero_1  output  1  bank non-empty and head is all-zero
  o_runs_0, o_runs_1  output  16  terminators written per bank (REQ-019)

Function
REQ-003 Two independent circular FIFO banks SHALL each hold 2**ADDR_WIDTH records, with write pointer, read pointer and occupancy counter of ADDR_WIDTH+1 bits.
REQ-004 A write SHALL occur on a rising edge when i_valid=1 and the bank selected by o_dest is not full; the record goes to that bank.
REQ-005 i_valid=1 while the selected bank is full SHALL drop nothing: no write, pointers unchanged; upstream holds data because o_full stalls it.
REQ-006 o_full SHALL be combinational: occupancy of bank o_dest equals 2**ADDR_WIDTH.
REQ-007 A pop SHALL occur on bank n when i_rd_n=1 and o_empty_n=0; i_rd_n on an empty bank is ignored.
REQ-008 Write and pop on the same bank in one cycle SHALL leave occupancy unchanged and advance both pointers; on a full bank the write is blocked (REQ-004), pop proceeds, occupancy decrements.
REQ-009 Pointers SHALL wrap modulo 2**ADDR_WIDTH with no gap or duplicate.
REQ-010 o_data_n SHALL present the record at read pointer n with zero latency; value undefined while empty.
REQ-011 o_min_zero_n SHALL be 1 exactly when o_empty_n=0 and o_data_n is all-zero.
REQ-012 o_dest SHALL toggle on the rising edge where i_switch=1; a record with i_valid=1 in that same cycle SHALL be written to the pre-toggle bank.
REQ-013 Write-to-read latency SHALL be one cycle: a record written at edge k is visible on o_data_n with o_empty_n=0 after edge k.
REQ-014 Bank state machine per bank: EMPTY (occ=0), PARTIAL, FULL (occ=max); transitions only by REQ-004/007/008 counts; no other state.
REQ-015 Records, including terminators, SHALL be stored unmodified in arrival order per bank.

Reset
REQ-016 While i_rst=1 at a rising edge, all pointers and occupancy counters SHALL clear, o_dest SHALL become 0, and writes/pops that cycle SHALL be ignored.
REQ-017 After reset: o_empty_0=o_empty_1=1, o_full=0, o_min_zero_0/1=0, o_runs_0/1=0; memory contents need not be cleared.
REQ-018 Reset mid-operation SHALL discard all buffered records; first write after reset lands at bank 0 address 0.

Configuration
REQ-019 With macro RUN_SPLITTER_STATS_EN defined, o_runs_n SHALL increment (saturating at 16'hFFFF) on each accepted all-zero write to bank n; without it, o_runs_0/1 SHALL be tied to 0 and no counter logic built.

Verification
REQ-020 Reset, then write 5,3,0 with o_dest=0 -> bank 0 occupancy 3, o_data_0=5, o_min_zero_0=0; after two pops o_min_zero_0=1.
REQ-021 ADDR_WIDTH=4: 16 writes to bank 0 -> o_full=1; 17th record held; one pop plus i_valid in same cycle -> pop only, next cycle write accepted, occupancy 16.
REQ-022 i_valid with data 7 and i_switch in same cycle -> 7 in bank 0, o_dest=1, next record 9 lands in bank 1, o_full reflects bank 1.
REQ-023 Write/pop 40 records through bank 1 interleaved -> order preserved across 2 pointer wraps, occupancy never exceeds 16.
REQ-024 i_rd_0 on empty bank 0 with simultaneous write of 4 -> occupancy 1, o_data_0=4.
REQ-025 Macro defined: write three terminators to bank 1, assert i_rst -> o_runs_1=3 before reset, 0 after; macro undefined -> o_runs_1 always 0.
